// File: rtl/datapath_pkg.sv
// Types and constants shared by the pipelined datapath stages.
package datapath_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_WORD = 32'b0;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    // Full-width unsigned bound check for a word-index PC.
    function automatic logic pc_in_range(input logic [WORD_W-1:0] pc,
                                         input logic [WORD_W-1:0] depth);
        return (pc < depth);
    endfunction

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: load captures a new entry, flush squashes it to a NOP
// bubble, kill only drops the valid bit, otherwise contents hold.
module ifid_register
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic              kill_i,
    input  logic [WORD_W-1:0] instr_i,
    input  logic [WORD_W-1:0] pc_i,
    input  logic [WORD_W-1:0] pc_next_i,
    output logic [WORD_W-1:0] instr_o,
    output logic [WORD_W-1:0] pc_o,
    output logic [WORD_W-1:0] pc_next_o,
    output logic              valid_o
);

    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] pc_next_q, pc_next_d;
    logic              valid_q, valid_d;

    // Next-entry selection, load > flush > kill > hold.
    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        pc_next_d = pc_next_q;
        valid_d   = valid_q;
        if (load_i) begin
            instr_d   = instr_i;
            pc_d      = pc_i;
            pc_next_d = pc_next_i;
            valid_d   = 1'b1;
        end else if (flush_i) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (kill_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q   <= NOP_WORD;
            pc_q      <= 32'd0;
            pc_next_q <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign pc_next_o = pc_next_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, honours redirect/stall, fills IF/ID,
// and parks in DONE after the last word of instruction memory.
module fetch_sequencer
    import datapath_pkg::*;
#(
    parameter int IMEM_DEPTH = 8,
    parameter int RESET_PC   = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [WORD_W-1:0] imem_pc,
    input  logic [WORD_W-1:0] imem_instr,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] ifid_instr,
    output logic [WORD_W-1:0] ifid_pc,
    output logic [WORD_W-1:0] ifid_pc_next,
    output logic              ifid_valid,
    output logic              done,
    output logic              fault
);

    localparam logic [WORD_W-1:0] DEPTH_W  = 32'(IMEM_DEPTH);
    localparam logic [WORD_W-1:0] LAST_PC  = 32'(IMEM_DEPTH - 1);
    localparam logic [WORD_W-1:0] RESET_PC_W = 32'(RESET_PC);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic              done_q, done_d;
    logic              ifid_load_s, ifid_flush_s, ifid_kill_s;
    logic              target_ok_s;

    assign target_ok_s = pc_in_range(redirect_pc, DEPTH_W);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect outranks stall, and BOOT ignores both.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redirect_valid) begin
                    state_d = target_ok_s ? RUN : DONE;
                end else if (stall) begin
                    state_d = RUN;
                end else if (pc_q == LAST_PC) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (redirect_valid && target_ok_s) begin
                    state_d = RUN;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // PC, fault and IF/ID control for the current state.
    always_comb begin
        pc_d         = pc_q;
        fault_d      = fault_q;
        ifid_load_s  = 1'b0;
        ifid_flush_s = 1'b0;
        ifid_kill_s  = 1'b0;
        case (state_q)
            BOOT: pc_d = pc_q;
            RUN: begin
                if (redirect_valid) begin
                    if (target_ok_s) begin
                        pc_d         = redirect_pc;
                        ifid_flush_s = 1'b1;
                    end else begin
                        fault_d     = 1'b1;
                        ifid_kill_s = 1'b1;
                    end
                end else if (stall) begin
                    pc_d = pc_q;
                end else begin
                    ifid_load_s = 1'b1;
                    // No wrap past the last word; DONE holds the PC there.
                    pc_d = (pc_q == LAST_PC) ? pc_q : pc_q + 32'd1;
                end
            end
            DONE: begin
                ifid_kill_s = ~stall;
                if (redirect_valid) begin
                    if (target_ok_s) begin
                        pc_d = redirect_pc;
                    end else begin
                        fault_d = 1'b1;
                    end
                end else begin
                    pc_d = pc_q;
                end
            end
            default: pc_d = RESET_PC_W;
        endcase
        done_d = (state_d == DONE);
    end

    // PC, sticky fault and done flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC_W;
            fault_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
            done_q  <= done_d;
        end
    end

    ifid_register u_ifid (
        .clk       (clk),
        .reset     (reset),
        .load_i    (ifid_load_s),
        .flush_i   (ifid_flush_s),
        .kill_i    (ifid_kill_s),
        .instr_i   (imem_instr),
        .pc_i      (pc_q),
        .pc_next_i (pc_q + 32'd1),
        .instr_o   (ifid_instr),
        .pc_o      (ifid_pc),
        .pc_next_o (ifid_pc_next),
        .valid_o   (ifid_valid)
    );

    assign imem_pc = pc_q;
    assign done    = done_q;
    assign fault   = fault_q;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the pipelined datapath. Owns the program counter, drives the word address into the combinational `InstructionMemory`, and registers the returned word into the IF/ID pipeline register. It honours stall from hazard detection and redirect from branch/jump resolution, and halts cleanly at the end of program memory.

## Interface

Parameters:
- `IMEM_DEPTH`, default 8: number of 32-bit words in instruction memory. Valid PCs are 0..IMEM_DEPTH-1.
- `RESET_PC`, default 0: PC value loaded on reset.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_pc` out 32: word index to `InstructionMemory`. Equals the PC register.
- `imem_instr` in 32: combinational instruction word for `imem_pc`.
- `stall` in 1: hold PC and IF/ID contents.
- `redirect_valid` in 1: load `redirect_pc` and squash IF/ID.
- `redirect_pc` in 32: word-index target.
- `ifid_instr` out 32: registered instruction.
- `ifid_pc` out 32: PC of `ifid_instr`.
- `ifid_pc_next` out 32: `ifid_pc + 1`.
- `ifid_valid` out 1: IF/ID holds a real instruction (0 = bubble).
- `done` out 1: the last word has been fetched; the sequencer is idle.
- `fault` out 1: sticky; a redirect targeted PC ≥ IMEM_DEPTH.

## Operation

- FSM states: BOOT, RUN, DONE.
- Reset, from any state and mid-operation:
  - State goes to BOOT.
  - PC = RESET_PC.
  - `ifid_instr` = 0, `ifid_pc` = 0, `ifid_pc_next` = 0, `ifid_valid` = 0.
  - `done` = 0, `fault` = 0.
- BOOT: a single cycle with no fetch capture. Next state is RUN. This gives memory contents one settled cycle after reset.
- RUN, priority per cycle is redirect > stall > advance:
  - Redirect with `redirect_pc` < IMEM_DEPTH:
    - PC ← `redirect_pc`.
    - `ifid_valid` ← 0, `ifid_instr` ← 0.
    - Stay in RUN.
  - Redirect with `redirect_pc` ≥ IMEM_DEPTH:
    - `fault` ← 1.
    - `ifid_valid` ← 0.
    - PC unchanged.
    - Go to DONE.
  - Stall, no redirect: PC and all `ifid_*` hold.
  - Advance:
    - `ifid_instr` ← `imem_instr`, `ifid_pc` ← PC, `ifid_pc_next` ← PC+1, `ifid_valid` ← 1.
    - If PC = IMEM_DEPTH-1, go to DONE and leave PC unchanged (no wrap-around). Otherwise PC ← PC+1.
- DONE:
  - `done` = 1.
  - Each cycle: `ifid_valid` ← 0, unless `stall` is high, in which case `ifid_*` hold so the last instruction is not lost.
  - A redirect with an in-range target: PC ← target, `done` ← 0, go to RUN.
  - A redirect with an out-of-range target sets `fault` and stays in DONE.
- Arithmetic:
  - All PC math is 32-bit unsigned and wraps modulo 2^32.
  - The range check compares the full 32 bits against IMEM_DEPTH.
- `stall` and `redirect_valid` are ignored in BOOT.

## Timing

- `imem_pc` changes one cycle after the event that updates PC. `imem_instr` is combinational within the same cycle.
- Fetch latency: the word at PC appears on `ifid_instr` with `ifid_valid` = 1 on the edge that advances PC. That is one cycle after PC is presented.
- First valid IF/ID: second rising edge after reset deasserts (BOOT edge, then first RUN edge).
- Redirect penalty: one bubble. The target instruction is valid in IF/ID two edges after `redirect_valid` is sampled.
- Stall for N cycles holds `imem_pc` and `ifid_*` for exactly N cycles. No instruction is dropped or duplicated.
- `done` asserts on the same edge that captures word IMEM_DEPTH-1.

## Structure

- Shared package `datapath_pkg` holds:
  - the state enum `fetch_state_t` (BOOT, RUN, DONE)
  - `WORD_W = 32`
  - the `NOP_WORD = 32'b0` constant used for squashed IF/ID contents.
- One sub-module is natural: `ifid_register`. It is the IF/ID pipeline register with load, hold and clear inputs, and it is reusable by later pipeline stages.
- `InstructionMemory` stays external. This block only drives its `pc` input.

## Test plan

- Reset, then run with memory preloaded 0..7 = 0x11..0x18:
  - `ifid_valid` first rises on the 2nd edge with `ifid_instr` = 0x11, `ifid_pc` = 0.
  - Words 0x11..0x18 follow in order.
  - `done` = 1 with `ifid_pc` = 7.
  - `imem_pc` stays at 7.
- At PC = 3, assert `stall` for 3 cycles:
  - `ifid_pc` = 2 is held for 3 cycles.
  - The sequence resumes 3,4,… with no gap or duplicate.
- At PC = 5, pulse `redirect_valid` with `redirect_pc` = 1:
  - One bubble (`ifid_valid` = 0).
  - Then `ifid_pc` = 1, 2, …
- Stall and redirect asserted together, target 6: redirect wins, PC = 6 on the next cycle.
- Redirect to target 9:
  - `fault` = 1 and stays set.
  - `done` = 1.
  - A later redirect to 0 resumes fetch while `fault` stays 1, until reset clears it.
- Assert `reset` mid-run at PC = 4:
  - On the next edge, PC = 0, `ifid_valid` = 0, `done` = 0, `fault` = 0.
  - The BOOT cycle is observed again.
